// File: rtl/xor_mem_arbiter_pkg.sv
// rtl/xor_mem_arbiter_pkg.sv - shared types, defaults and helpers for the memory arbiter
package xor_mem_arbiter_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_NCLIENT = 4;
    localparam int DEF_AW      = 10;
    localparam int DEF_DW      = 8;
    localparam int DEF_RD_LAT  = 1;

    // Index one past idx, wrapping at n; used for the round-robin pointer.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/xor_mem_arbiter_if.sv
// rtl/xor_mem_arbiter_if.sv - client request/response bus for the memory arbiter
interface xor_mem_arbiter_if
    import xor_mem_arbiter_pkg::*;
#(
    parameter int NCLIENT = DEF_NCLIENT,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW
);
    logic [NCLIENT-1:0]    req_valid;
    logic [NCLIENT-1:0]    req_we;
    logic [NCLIENT*AW-1:0] req_addr;
    logic [NCLIENT*DW-1:0] req_wdata;
    logic [NCLIENT-1:0]    req_ready;
    logic [NCLIENT-1:0]    resp_valid;
    logic [NCLIENT*DW-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/xor_mem_arbiter_rr_dual_grant.sv
// rtl/xor_mem_arbiter_rr_dual_grant.sv - round-robin arbiter issuing up to two one-hot grants
module rr_dual_grant
    import xor_mem_arbiter_pkg::*;
#(
    parameter int N  = DEF_NCLIENT,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant1,
    output logic [N-1:0]  o_grant2,
    output logic [PW-1:0] o_next_ptr
);
    logic [PW-1:0] w_idx;
    logic          w_found1;
    logic          w_found2;

    // Scan from the pointer; first requester takes port 1, second takes port 2.
    always_comb begin
        o_grant1   = '0;
        o_grant2   = '0;
        o_next_ptr = i_ptr;
        w_idx      = '0;
        w_found1   = 1'b0;
        w_found2   = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_idx = PW'((int'(i_ptr) + i) % N);
            if (i_req[w_idx] && !w_found2) begin
                if (!w_found1) begin
                    o_grant1[w_idx] = 1'b1;
                    w_found1        = 1'b1;
                end else begin
                    o_grant2[w_idx] = 1'b1;
                    w_found2        = 1'b1;
                end
                o_next_ptr = PW'(wrap_inc(int'(w_idx), N));
            end
        end
    end

endmodule

// File: rtl/xor_mem_arbiter.sv
// rtl/xor_mem_arbiter.sv - clears a 2-write/4-read memory, then arbitrates client reads and writes
module xor_mem_arbiter
    import xor_mem_arbiter_pkg::*;
#(
    parameter int NCLIENT = DEF_NCLIENT,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int RD_LAT  = DEF_RD_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_start,
    xor_mem_arbiter_if.slave      bus,
    output logic                  init_done,
    output logic [3:0]            mem_enW,
    output logic [AW-1:0]         mem_wa1,
    output logic [AW-1:0]         mem_wa2,
    output logic [DW-1:0]         mem_w1,
    output logic [DW-1:0]         mem_w2,
    output logic [AW-1:0]         mem_ra1,
    output logic [AW-1:0]         mem_ra2,
    output logic [AW-1:0]         mem_ra3,
    output logic [AW-1:0]         mem_ra4,
    input  logic [DW-1:0]         mem_r1,
    input  logic [DW-1:0]         mem_r2,
    input  logic [DW-1:0]         mem_r3,
    input  logic [DW-1:0]         mem_r4
);
    localparam int PW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

    state_t             r_state;
    logic [AW-2:0]      r_sweep;
    logic [PW-1:0]      r_rr_ptr;
    logic               r_init_done;
    logic [RD_LAT-1:0]  r_rd_pipe [NCLIENT];

    logic               w_run_ok;
    logic               w_sweep;
    logic [NCLIENT-1:0] w_wreq;
    logic [NCLIENT-1:0] w_g1;
    logic [NCLIENT-1:0] w_g2_raw;
    logic [NCLIENT-1:0] w_g2;
    logic [PW-1:0]      w_ptr_raw;
    logic [PW-1:0]      w_ptr_next;
    logic [PW-1:0]      w_g1_idx;
    logic [AW-1:0]      w_wa1;
    logic [AW-1:0]      w_wa2;
    logic [DW-1:0]      w_wd1;
    logic [DW-1:0]      w_wd2;
    logic               w_same;
    logic [NCLIENT-1:0] w_rd_haz;
    logic [NCLIENT-1:0] w_ready;
    logic [NCLIENT-1:0] w_rd_acc;
    logic [NCLIENT-1:0] w_resp_valid;
    logic [AW-1:0]      w_ra [4];
    logic [DW-1:0]      w_mr [4];

    // Requests are only served in RUN, and never in the cycle a clear is requested.
    assign w_run_ok = (r_state == ST_RUN) && !clear_start;
    // Gate the sweep with reset so the memory sees no writes while reset is held.
    assign w_sweep  = (r_state == ST_INIT) && rst_n;
    assign w_wreq   = w_run_ok ? (bus.req_valid & bus.req_we) : '0;

    rr_dual_grant #(
        .N  (NCLIENT),
        .PW (PW)
    ) u_grant (
        .i_req      (w_wreq),
        .i_ptr      (r_rr_ptr),
        .o_grant1   (w_g1),
        .o_grant2   (w_g2_raw),
        .o_next_ptr (w_ptr_raw)
    );

    // Select the address/data of each granted client.
    always_comb begin
        w_wa1    = '0;
        w_wa2    = '0;
        w_wd1    = '0;
        w_wd2    = '0;
        w_g1_idx = '0;
        for (int i = 0; i < NCLIENT; i++) begin
            if (w_g1[i]) begin
                w_wa1    = bus.req_addr[i*AW +: AW];
                w_wd1    = bus.req_wdata[i*DW +: DW];
                w_g1_idx = PW'(i);
            end
            if (w_g2_raw[i]) begin
                w_wa2 = bus.req_addr[i*AW +: AW];
                w_wd2 = bus.req_wdata[i*DW +: DW];
            end
        end
    end

    // A second write to the first write's address waits; the pointer then stops after port 1.
    assign w_same     = (|w_g1) && (|w_g2_raw) && (w_wa1 == w_wa2);
    assign w_g2       = w_same ? '0 : w_g2_raw;
    assign w_ptr_next = w_same ? PW'(wrap_inc(int'(w_g1_idx), NCLIENT)) : w_ptr_raw;

    // Writers are ready only when granted; readers unless their address is written this cycle.
    always_comb begin
        w_rd_haz = '0;
        w_ready  = '0;
        w_rd_acc = '0;
        for (int i = 0; i < NCLIENT; i++) begin
            w_rd_haz[i] = ((|w_g1) && (bus.req_addr[i*AW +: AW] == w_wa1)) ||
                          ((|w_g2) && (bus.req_addr[i*AW +: AW] == w_wa2));
            w_ready[i]  = w_run_ok && (bus.req_we[i] ? (w_g1[i] | w_g2[i]) : !w_rd_haz[i]);
            w_rd_acc[i] = bus.req_valid[i] && !bus.req_we[i] && w_ready[i];
        end
    end

    assign bus.req_ready = w_ready;

    // Drive the two write ports from either the clear sweep or the granted clients.
    always_comb begin
        mem_enW = 4'b0000;
        mem_wa1 = '0;
        mem_wa2 = '0;
        mem_w1  = '0;
        mem_w2  = '0;
        if (w_sweep) begin
            mem_enW = 4'b0011;
            mem_wa1 = {r_sweep, 1'b0};
            mem_wa2 = {r_sweep, 1'b1};
        end else begin
            if (|w_g1) begin
                mem_enW[0] = 1'b1;
                mem_wa1    = w_wa1;
                mem_w1     = w_wd1;
            end
            if (|w_g2) begin
                mem_enW[1] = 1'b1;
                mem_wa2    = w_wa2;
                mem_w2     = w_wd2;
            end
        end
    end

    // Read ports follow the client addresses directly; unused ports stay at 0.
    for (genvar k = 0; k < 4; k++) begin : g_rport
        if (k < NCLIENT) begin : g_used
            assign w_ra[k] = bus.req_addr[k*AW +: AW];
        end else begin : g_unused
            assign w_ra[k] = '0;
        end
    end

    assign mem_ra1 = w_ra[0];
    assign mem_ra2 = w_ra[1];
    assign mem_ra3 = w_ra[2];
    assign mem_ra4 = w_ra[3];
    assign w_mr[0] = mem_r1;
    assign w_mr[1] = mem_r2;
    assign w_mr[2] = mem_r3;
    assign w_mr[3] = mem_r4;

    // Sweep/run state machine, round-robin pointer and the registered init_done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_sweep     <= '0;
            r_rr_ptr    <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_rr_ptr <= w_ptr_next;
            case (r_state)
                ST_INIT: begin
                    if (clear_start) begin
                        r_sweep <= '0;
                    end else if (&r_sweep) begin
                        r_sweep     <= '0;
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_sweep <= r_sweep + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_start) begin
                        r_sweep     <= '0;
                        r_state     <= ST_INIT;
                        r_init_done <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign init_done = r_init_done;

    // Per-client valid pipeline matching the memory read latency; a clear does not flush it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCLIENT; i++) begin
                r_rd_pipe[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCLIENT; i++) begin
                r_rd_pipe[i][0] <= w_rd_acc[i];
                for (int j = 1; j < RD_LAT; j++) begin
                    r_rd_pipe[i][j] <= r_rd_pipe[i][j-1];
                end
            end
        end
    end

    for (genvar i = 0; i < NCLIENT; i++) begin : g_resp
        assign w_resp_valid[i]                = r_rd_pipe[i][RD_LAT-1];
        assign bus.resp_rdata[i*DW +: DW]     = w_resp_valid[i] ? w_mr[i] : '0;
    end

    assign bus.resp_valid = w_resp_valid;

endmodule

// File: tb/tb_xor_mem_arbiter.sv
// tb/tb_xor_mem_arbiter.sv - directed vector bench for xor_mem_arbiter
module tb_xor_mem_arbiter;
    logic       clk;
    logic       rst_n;
    logic       clear_start;
    logic       init_done;
    logic [3:0] mem_enW;
    logic [9:0] mem_wa1, mem_wa2, mem_ra1, mem_ra2, mem_ra3, mem_ra4;
    logic [7:0] mem_w1, mem_w2, mem_r1, mem_r2, mem_r3, mem_r4;
    logic       tb_fill;
    logic [7:0] mem [1024];

    int checks;
    int failures;
    int n;
    int bad;

    xor_mem_arbiter_if #(.NCLIENT(4), .AW(10), .DW(8)) bus ();

    xor_mem_arbiter #(.NCLIENT(4), .AW(10), .DW(8), .RD_LAT(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_start (clear_start),
        .bus         (bus),
        .init_done   (init_done),
        .mem_enW     (mem_enW),
        .mem_wa1     (mem_wa1),
        .mem_wa2     (mem_wa2),
        .mem_w1      (mem_w1),
        .mem_w2      (mem_w2),
        .mem_ra1     (mem_ra1),
        .mem_ra2     (mem_ra2),
        .mem_ra3     (mem_ra3),
        .mem_ra4     (mem_ra4),
        .mem_r1      (mem_r1),
        .mem_r2      (mem_r2),
        .mem_r3      (mem_r3),
        .mem_r4      (mem_r4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: two write ports, four registered read ports (latency 1).
    always @(posedge clk) begin
        if (tb_fill) begin
            for (int a = 0; a < 1024; a++) mem[a] <= 8'hA5;
        end else begin
            if (mem_enW[0]) mem[mem_wa1] <= mem_w1;
            if (mem_enW[1]) mem[mem_wa2] <= mem_w2;
        end
        mem_r1 <= mem[mem_ra1];
        mem_r2 <= mem[mem_ra2];
        mem_r3 <= mem[mem_ra3];
        mem_r4 <= mem[mem_ra4];
    end

    typedef struct {
        logic [3:0]       valid;
        logic [3:0]       we;
        logic [3:0][9:0]  addr;
        logic [3:0][7:0]  wd;
        logic [3:0]       ready;
        logic [3:0]       enw;
        logic [9:0]       wa1;
        logic [9:0]       wa2;
        logic [7:0]       w1;
        logic [7:0]       w2;
        logic [3:0]       rv;
        logic [3:0][7:0]  rd;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV];

    function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] we,
                                input logic [39:0] addr, input logic [31:0] wd,
                                input logic [3:0] ready, input logic [3:0] enw,
                                input logic [9:0] wa1, input logic [9:0] wa2,
                                input logic [7:0] w1, input logic [7:0] w2,
                                input logic [3:0] rv, input logic [31:0] rd);
        vec_t v;
        v.valid = valid; v.we = we; v.addr = addr; v.wd = wd;
        v.ready = ready; v.enw = enw; v.wa1 = wa1; v.wa2 = wa2;
        v.w1 = w1; v.w2 = w2; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    // Counts rising edges until init_done, bounded so a stuck sweep cannot hang the run.
    task automatic wait_init(output int cnt);
        cnt = 0;
        while (init_done !== 1'b1 && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clear_start = 1'b0;
        tb_fill = 1'b1;
        set_idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tb_fill = 1'b0;
        bus.req_valid = 4'b0001; bus.req_we = 4'b0001;
        bus.req_addr[9:0] = 10'd7; bus.req_wdata[7:0] = 8'h55;
        #1;
        chk("rst_init_done", init_done, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_mem_enW", mem_enW, 0);
        chk("rst_mem_wa", {mem_wa1, mem_wa2}, 0);
        chk("rst_mem_w", {mem_w1, mem_w2}, 0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init0_enW", mem_enW, 4'b0011);
        chk("init0_wa1", mem_wa1, 0);
        chk("init0_wa2", mem_wa2, 1);
        chk("init0_w", {mem_w1, mem_w2}, 0);
        chk("init0_ready", bus.req_ready, 0);
        chk("init0_done", init_done, 0);
        set_idle();
        wait_init(n);
        chk("init_cycles", n, 512);
        chk("run_init_done", init_done, 1);

        bad = 0;
        for (int c = 0; c <= 256; c++) begin
            @(negedge clk);
            if (c > 0 && (bus.resp_valid !== 4'hF || bus.resp_rdata !== 32'h0)) bad++;
            if (c < 256) begin
                bus.req_valid = 4'hF;
                bus.req_we = 4'h0;
                for (int i = 0; i < 4; i++) bus.req_addr[i*10 +: 10] = 10'(4*c + i);
            end else begin
                set_idle();
            end
            #1;
            if (c < 256 && bus.req_ready !== 4'hF) bad++;
        end
        chk("sweep_readback_bad", bad, 0);

        vt[0]  = mk(4'b1111, 4'b1111, {10'd103,10'd102,10'd101,10'd100}, 32'h03020100, 4'b0011, 4'b0011, 10'd100, 10'd101, 8'h00, 8'h01, 4'b0000, 32'h0);
        vt[1]  = mk(4'b1111, 4'b1111, {10'd103,10'd102,10'd111,10'd110}, 32'h03021110, 4'b1100, 4'b0011, 10'd102, 10'd103, 8'h02, 8'h03, 4'b0000, 32'h0);
        vt[2]  = mk(4'b1111, 4'b1111, {10'd113,10'd112,10'd111,10'd110}, 32'h13121110, 4'b0011, 4'b0011, 10'd110, 10'd111, 8'h10, 8'h11, 4'b0000, 32'h0);
        vt[3]  = mk(4'b1111, 4'b1111, {10'd113,10'd112,10'd121,10'd120}, 32'h13122120, 4'b1100, 4'b0011, 10'd112, 10'd113, 8'h12, 8'h13, 4'b0000, 32'h0);
        vt[4]  = mk(4'b0101, 4'b0101, {10'd0,10'd20,10'd0,10'd10},       32'h0014000A, 4'b1111, 4'b0011, 10'd10,  10'd20,  8'h0A, 8'h14, 4'b0000, 32'h0);
        vt[5]  = mk(4'b0101, 4'b0000, {10'd0,10'd20,10'd0,10'd10},       32'h0,        4'b1111, 4'b0000, 10'd0,   10'd0,   8'h00, 8'h00, 4'b0000, 32'h0);
        vt[6]  = mk(4'b0000, 4'b0000, 40'h0,                             32'h0,        4'b1111, 4'b0000, 10'd0,   10'd0,   8'h00, 8'h00, 4'b0101, 32'h0014000A);
        vt[7]  = mk(4'b1000, 4'b1000, {10'd50,10'd0,10'd0,10'd0},        32'h33000000, 4'b1111, 4'b0001, 10'd50,  10'd0,   8'h33, 8'h00, 4'b0000, 32'h0);
        vt[8]  = mk(4'b1010, 4'b1010, {10'd30,10'd0,10'd30,10'd0},       32'h33001100, 4'b0111, 4'b0001, 10'd30,  10'd0,   8'h11, 8'h00, 4'b0000, 32'h0);
        vt[9]  = mk(4'b1000, 4'b1000, {10'd30,10'd0,10'd0,10'd0},        32'h33000000, 4'b1111, 4'b0001, 10'd30,  10'd0,   8'h33, 8'h00, 4'b0000, 32'h0);
        vt[10] = mk(4'b0001, 4'b0000, {10'd0,10'd0,10'd0,10'd30},        32'h0,        4'b1111, 4'b0000, 10'd0,   10'd0,   8'h00, 8'h00, 4'b0000, 32'h0);
        vt[11] = mk(4'b0000, 4'b0000, 40'h0,                             32'h0,        4'b1111, 4'b0000, 10'd0,   10'd0,   8'h00, 8'h00, 4'b0001, 32'h00000033);
        vt[12] = mk(4'b0011, 4'b0001, {10'd0,10'd0,10'd40,10'd40},       32'h00000028, 4'b1101, 4'b0001, 10'd40,  10'd0,   8'h28, 8'h00, 4'b0000, 32'h0);
        vt[13] = mk(4'b0010, 4'b0000, {10'd0,10'd0,10'd40,10'd0},        32'h0,        4'b1111, 4'b0000, 10'd0,   10'd0,   8'h00, 8'h00, 4'b0000, 32'h0);
        vt[14] = mk(4'b0000, 4'b0000, 40'h0,                             32'h0,        4'b1111, 4'b0000, 10'd0,   10'd0,   8'h00, 8'h00, 4'b0010, 32'h00002800);
        vt[15] = mk(4'b0100, 4'b0000, {10'd0,10'd10,10'd0,10'd0},        32'h0,        4'b1111, 4'b0000, 10'd0,   10'd0,   8'h00, 8'h00, 4'b0000, 32'h0);
        vt[16] = mk(4'b0100, 4'b0000, {10'd0,10'd20,10'd0,10'd0},        32'h0,        4'b1111, 4'b0000, 10'd0,   10'd0,   8'h00, 8'h00, 4'b0100, 32'h000A0000);
        vt[17] = mk(4'b0000, 4'b0000, 40'h0,                             32'h0,        4'b1111, 4'b0000, 10'd0,   10'd0,   8'h00, 8'h00, 4'b0100, 32'h00140000);
        vt[18] = mk(4'b0111, 4'b0011, {10'd0,10'd60,10'd61,10'd60},      32'h00006677, 4'b1011, 4'b0011, 10'd61,  10'd60,  8'h66, 8'h77, 4'b0000, 32'h0);
        vt[19] = mk(4'b0100, 4'b0000, {10'd0,10'd60,10'd0,10'd0},        32'h0,        4'b1111, 4'b0000, 10'd0,   10'd0,   8'h00, 8'h00, 4'b0000, 32'h0);
        vt[20] = mk(4'b0000, 4'b0000, 40'h0,                             32'h0,        4'b1111, 4'b0000, 10'd0,   10'd0,   8'h00, 8'h00, 4'b0100, 32'h00770000);
        vt[21] = mk(4'b0000, 4'b0000, 40'h0,                             32'h0,        4'b1111, 4'b0000, 10'd0,   10'd0,   8'h00, 8'h00, 4'b0000, 32'h0);

        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            bus.req_valid = vt[v].valid;
            bus.req_we    = vt[v].we;
            bus.req_addr  = vt[v].addr;
            bus.req_wdata = vt[v].wd;
            #1;
            chk($sformatf("vec%0d_ready", v), bus.req_ready, vt[v].ready);
            chk($sformatf("vec%0d_enW", v), mem_enW, vt[v].enw);
            chk($sformatf("vec%0d_wa", v), {mem_wa1, mem_wa2}, {vt[v].wa1, vt[v].wa2});
            chk($sformatf("vec%0d_wdata", v), {mem_w1, mem_w2}, {vt[v].w1, vt[v].w2});
            chk($sformatf("vec%0d_resp_valid", v), bus.resp_valid, vt[v].rv);
            chk($sformatf("vec%0d_resp_rdata", v), bus.resp_rdata, vt[v].rd);
        end

        // Clear in RUN with a read in flight.
        @(negedge clk);
        set_idle();
        bus.req_valid[1] = 1'b1;
        bus.req_addr[19:10] = 10'd40;
        #1;
        chk("clr_rd_ready", bus.req_ready[1], 1);
        @(negedge clk);
        set_idle();
        clear_start = 1'b1;
        bus.req_valid[0] = 1'b1; bus.req_we[0] = 1'b1;
        bus.req_addr[9:0] = 10'd41; bus.req_wdata[7:0] = 8'h99;
        #1;
        chk("clr_resp_valid", bus.resp_valid, 4'b0010);
        chk("clr_resp_rdata", bus.resp_rdata[15:8], 8'h28);
        chk("clr_req_ready", bus.req_ready, 4'b0000);
        chk("clr_enW", mem_enW, 4'b0000);
        chk("clr_init_done_still", init_done, 1);
        @(negedge clk);
        clear_start = 1'b0;
        set_idle();
        #1;
        chk("clr_init_done_low", init_done, 0);
        chk("clr_sweep_enW", mem_enW, 4'b0011);
        chk("clr_sweep_wa", {mem_wa1, mem_wa2}, {10'd0, 10'd1});
        chk("clr_resp_single", bus.resp_valid, 0);
        wait_init(n);
        chk("clr_init_cycles", n, 512);
        @(negedge clk);
        bus.req_valid[1] = 1'b1;
        bus.req_addr[19:10] = 10'd40;
        @(negedge clk);
        set_idle();
        #1;
        chk("clr_rd40_valid", bus.resp_valid, 4'b0010);
        chk("clr_rd40_data", bus.resp_rdata[15:8], 8'h00);

        // Clear during INIT restarts the sweep from address 0.
        @(negedge clk);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        #1;
        chk("restart_wa", {mem_wa1, mem_wa2}, {10'd0, 10'd1});
        wait_init(n);
        chk("restart_init_cycles", n, 512);

        // Reset mid-RUN discards a pending response.
        @(negedge clk);
        bus.req_valid[0] = 1'b1;
        bus.req_addr[9:0] = 10'd10;
        @(posedge clk);
        #1;
        set_idle();
        chk("rstrun_pre_rv", bus.resp_valid, 4'b0001);
        #1 rst_n = 1'b0;
        #1;
        chk("rstrun_rv", bus.resp_valid, 0);
        chk("rstrun_init_done", init_done, 0);
        chk("rstrun_enW", mem_enW, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(n);
        chk("rstrun_init_cycles", n, 512);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
